// File: rtl/tx_frame_serializer_pkg.sv
// Shared types and constants for the TX frame serializer.
// Optional feature macro: SEQ_HDR_EN (adds a sequence-header beat per frame).
package tx_frame_serializer_pkg;

  localparam int TX_BEAT_W = 64;
  localparam logic [15:0] TX_HDR_MAGIC = 16'hA55A;

  // Encoder field widths: word0 = {qty, price, inst_id}, word1 = {reserved, latency, side}
  localparam int INST_ID_W = 16;
  localparam int PRICE_W   = 32;
  localparam int SIZE_W    = 16;
  localparam int TS_W      = 32;

  typedef struct packed {
    logic [TX_BEAT_W-1:0] word1;
    logic [TX_BEAT_W-1:0] word0;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef SEQ_HDR_EN
    ST_HDR   = 2'd1,
`endif
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_e;

  function automatic logic [TX_BEAT_W-1:0] hdr_word(input logic [31:0] seq);
    return {TX_HDR_MAGIC, 16'h0000, seq};
  endfunction

endpackage

// File: rtl/tx_frame_fifo.sv
// DEPTH x 128-bit frame FIFO; head entry is readable combinationally.
module tx_frame_fifo
  import tx_frame_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  frame_t                     i_din,
  input  logic                       i_pop,
  output frame_t                     o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  frame_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/tx_frame_serializer.sv
// Buffers single-cycle order frames and emits each as a 64-bit valid/ready beat stream.
// Define SEQ_HDR_EN to prefix every frame with a {magic, 0, seq} header beat.
module tx_frame_serializer
  import tx_frame_serializer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [63:0]                in_word0,
  input  logic [63:0]                in_word1,
  output logic [63:0]                out_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       out_tlast,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LVL  = LW'(1);
`ifdef SEQ_HDR_EN
  localparam state_e ST_FIRST = ST_HDR;
`else
  localparam state_e ST_FIRST = ST_BEAT0;
`endif

  state_e            r_state;
  state_e            w_nxt;
  logic [DROP_W-1:0] r_drop_cnt;
  frame_t            w_head;
  frame_t            w_din;
  logic              w_push;
  logic              w_drop;
  logic              w_hs;
  logic              w_pop;

  // Full check uses the registered level, so a same-cycle pop never makes room.
  assign w_push = in_valid && (fifo_level != FULL_LVL);
  assign w_drop = in_valid && (fifo_level == FULL_LVL);
  assign w_hs   = out_tvalid && out_tready;
  assign w_pop  = (r_state == ST_BEAT1) && w_hs;
  assign w_din  = '{word1: in_word1, word0: in_word0};

  tx_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (fifo_level)
  );

`ifdef SEQ_HDR_EN
  logic [31:0] r_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_seq <= '0;
    else if (w_pop) r_seq <= r_seq + 32'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    out_tdata = '0;
    out_tlast = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fifo_level != '0) w_nxt = ST_FIRST;
      end
`ifdef SEQ_HDR_EN
      ST_HDR: begin
        out_tdata = hdr_word(r_seq);
        if (w_hs) w_nxt = ST_BEAT0;
      end
`endif
      ST_BEAT0: begin
        out_tdata = w_head.word0;
        if (w_hs) w_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        out_tdata = w_head.word1;
        out_tlast = 1'b1;
        if (w_hs) w_nxt = (fifo_level > ONE_LVL) ? ST_FIRST : ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign out_tvalid = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: queue scoreboard of expected beats plus a negedge monitor.
module tb_tx_frame_serializer;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_word0;
  logic [63:0] in_word1;
  logic [63:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  logic [DROP_W-1:0]          drop_cnt;

  tx_frame_serializer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_word0   (in_word0),
    .in_word1   (in_word1),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_e;
  logic [31:0] m_seq;
  logic [63:0] f1, f2, f3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one input frame and queues the beats it should produce; returns the first beat.
  task automatic enq(input logic [63:0] w0, input logic [63:0] w1, output logic [63:0] first);
`ifdef SEQ_HDR_EN
    first = {16'hA55A, 16'h0000, m_seq};
    exp_q.push_back({1'b0, first});
    m_seq = m_seq + 32'd1;
`else
    first = w0;
`endif
    exp_q.push_back({1'b0, w0});
    exp_q.push_back({1'b1, w1});
    in_valid = 1'b1; in_word0 = w0; in_word1 = w1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drive_dropped(input logic [63:0] w0, input logic [63:0] w1);
    in_valid = 1'b1; in_word0 = w0; in_word1 = w1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (exp_q.size() != 0 || fifo_level != '0 || out_tvalid); i++) step();
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_level", 64'(fifo_level), 64'd0);
  endtask

  task automatic wait_last();
    for (int i = 0; i < 10 && !(out_tvalid && out_tlast); i++) step();
    chk("reach_last", 64'(out_tlast), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_tvalid === 1'b1 && out_tready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got last=%b data=%h expected no beat", out_tlast, out_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_tlast, out_tdata} !== mon_e) begin
          n_err++;
          $display("FAIL beat: got last=%b data=%h expected last=%b data=%h",
                   out_tlast, out_tdata, mon_e[64], mon_e[63:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word0 = '0; in_word1 = '0; out_tready = 1'b0;
    m_seq = '0;
    #12;
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_tlast", 64'(out_tlast), 64'd0);
    chk("rst_tdata", out_tdata, 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Single frame, two-cycle latency
    out_tready = 1'b1;
    enq(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, f1);
    chk("lat_edge_k", 64'(out_tvalid), 64'd0);
    step();
    chk("lat_edge_k1", 64'(out_tvalid), 64'd1);
    chk("first_beat", out_tdata, f1);
    drain();

    // Stall on the first beat
    out_tready = 1'b0;
    enq(64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0001, f1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(out_tvalid), 64'd1);
      chk("stall_data", out_tdata, f1);
      chk("stall_level", 64'(fifo_level), 64'd1);
      step();
    end
    out_tready = 1'b1;
    drain();

    // Overflow: 6 frames into a 4-deep FIFO
    out_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) enq(64'h3000_0000_0000_0000 + 64'(i), 64'h3100_0000_0000_0000 + 64'(i), f1);
      else       drive_dropped(64'h3000_0000_0000_0000 + 64'(i), 64'h3100_0000_0000_0000 + 64'(i));
    end
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    out_tready = 1'b1;
    drain();
    chk("ovf_drop_hold", 64'(drop_cnt), 64'd2);

    // Push coincident with the final-beat handshake at level 2
    out_tready = 1'b0;
    enq(64'h4100_0000_0000_0001, 64'h4200_0000_0000_0001, f1);
    enq(64'h4100_0000_0000_0002, 64'h4200_0000_0000_0002, f2);
    out_tready = 1'b1;
    wait_last();
    enq(64'h4100_0000_0000_0003, 64'h4200_0000_0000_0003, f3);
    chk("pp_level", 64'(fifo_level), 64'd2);
    chk("pp_no_bubble", 64'(out_tvalid), 64'd1);
    chk("pp_next_first", out_tdata, f2);
    drain();

    // Asynchronous reset while the final beat is stalled
    out_tready = 1'b0;
    enq(64'h5100_0000_0000_0001, 64'h5200_0000_0000_0001, f1);
    drive_dropped(64'h0, 64'h0);
    out_tready = 1'b1;
    wait_last();
    out_tready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_seq = '0;
    #1;
    chk("arst_tvalid", 64'(out_tvalid), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    out_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_idle", 64'(out_tvalid), 64'd0);
    end
    enq(64'h6100_0000_0000_0001, 64'h6200_0000_0000_0001, f1);
    drain();

`ifdef SEQ_HDR_EN
    for (int i = 0; i < 3; i++)
      enq(64'h7100_0000_0000_0000 + 64'(i), 64'h7200_0000_0000_0000 + 64'(i), f1);
    drain();
    force dut.r_seq = 32'hFFFF_FFFF;
    step();
    release dut.r_seq;
    m_seq = 32'hFFFF_FFFF;
    enq(64'h8100_0000_0000_0001, 64'h8200_0000_0000_0001, f1);
    chk("seq_wrap_hdr", f1, {16'hA55A, 16'h0000, 32'hFFFF_FFFF});
    enq(64'h8100_0000_0000_0002, 64'h8200_0000_0000_0002, f2);
    chk("seq_wrap_zero", f2, {16'hA55A, 16'h0000, 32'h0000_0000});
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
